// File: rtl/llr_fetcher.sv
// Walks LLR memory (count, then per-packet N/K header and LLR lines) and streams headers/lines to the SC core.
// Header 2 cycles after its address, first line 2 cycles after header accept; reads throttled so a 2-entry FIFO never overflows.
module llr_fetcher #(
  parameter int LLR_W         = 12,
  parameter int LLRS_PER_LINE = 16,
  parameter int PKT_STRIDE    = 33
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic [10:0]                      raddr,
  input  logic [LLR_W*LLRS_PER_LINE-1:0]   rdata,
  output logic                             hdr_valid,
  input  logic                             hdr_ready,
  output logic [9:0]                       hdr_n,
  output logic [7:0]                       hdr_k,
  output logic [6:0]                       hdr_idx,
  output logic                             llr_valid,
  input  logic                             llr_ready,
  output logic [LLR_W*LLRS_PER_LINE-1:0]   llr_data,
  output logic [4:0]                       llr_line,
  output logic                             llr_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int LINE_W = LLR_W * LLRS_PER_LINE;

  typedef enum logic [2:0] {IDLE, CNT_WAIT, CNT, HDR_WAIT, HDR, STREAM, FIN} state_t;

  typedef struct packed {
    logic [LINE_W-1:0] dat;
    logic [4:0]        line;
    logic              last;
  } beat_t;

  state_t      state;
  logic [6:0]  pkt_cnt;
  logic [10:0] base;
  logic [5:0]  iss_cnt;
  logic        pend;
  logic [4:0]  pend_line;
  logic        pend_last;
  beat_t       ent0, ent1;
  logic [1:0]  occ;

  logic [5:0]  nlines;
  logic        pop;
  logic [1:0]  in_use;
  logic        issue;
  logic        iss_last;
  logic        more_pkts;
  logic        n_ok;
  logic        last_pop;
  logic [10:0] next_base;
  beat_t       new_beat;

  assign nlines    = hdr_n[9:4];
  assign pop       = llr_valid && llr_ready;
  assign last_pop  = pop && ent0.last;
  // Slots committed after this cycle: FIFO entries left after the pop plus the read whose data lands now.
  assign in_use    = occ - {1'b0, pop} + {1'b0, pend};
  assign issue     = (state == STREAM) && (!hdr_valid || hdr_ready) &&
                     (iss_cnt < nlines) && (in_use < 2'd2);
  assign iss_last  = (iss_cnt == nlines - 6'd1);
  assign more_pkts = ({1'b0, hdr_idx} + 8'd1) < {1'b0, pkt_cnt};
  assign n_ok      = (rdata[9:0] == 10'd128) || (rdata[9:0] == 10'd256) || (rdata[9:0] == 10'd512);
  assign next_base = base + 11'(PKT_STRIDE);
  assign new_beat  = {rdata, pend_line, pend_last};

  assign busy      = (state != IDLE);
  assign llr_valid = (occ != 2'd0);
  assign llr_data  = ent0.dat;
  assign llr_line  = ent0.line;
  assign llr_last  = ent0.last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      raddr     <= '0;
      hdr_valid <= 1'b0;
      hdr_n     <= '0;
      hdr_k     <= '0;
      hdr_idx   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      pkt_cnt   <= '0;
      base      <= '0;
      iss_cnt   <= '0;
      pend      <= 1'b0;
      pend_line <= '0;
      pend_last <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= issue;
      if (issue) begin
        pend_line <= iss_cnt[4:0];
        pend_last <= iss_last;
        iss_cnt   <= iss_cnt + 6'd1;
        // Hold the final line's address so raddr only ever shows addresses actually read.
        raddr     <= iss_last ? raddr : raddr + 11'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            raddr   <= '0;
            err     <= 1'b0;
            hdr_idx <= '0;
            state   <= CNT_WAIT;
          end
        end
        CNT_WAIT: state <= CNT;
        CNT: begin
          pkt_cnt <= rdata[6:0];
          if (rdata[6:0] == 7'd0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            raddr <= 11'd1;
            base  <= 11'd1;
            state <= HDR_WAIT;
          end
        end
        HDR_WAIT: state <= HDR;
        HDR: begin
          hdr_n   <= rdata[9:0];
          hdr_k   <= rdata[17:10];
          iss_cnt <= '0;
          if (n_ok) begin
            hdr_valid <= 1'b1;
            raddr     <= base + 11'd1;
            state     <= STREAM;
          end else begin
            err <= 1'b1;
            if (more_pkts) begin
              base    <= next_base;
              raddr   <= next_base;
              hdr_idx <= hdr_idx + 7'd1;
              state   <= HDR_WAIT;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        STREAM: begin
          if (hdr_valid && hdr_ready) hdr_valid <= 1'b0;
          if (last_pop) begin
            if (more_pkts) begin
              base    <= next_base;
              raddr   <= next_base;
              hdr_idx <= hdr_idx + 7'd1;
              state   <= HDR_WAIT;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output FIFO; ent0 is always the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= new_beat;
          else             ent1 <= new_beat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= new_beat;
          end else begin
            ent0 <= ent1;
            ent1 <= new_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_fetcher.sv
// Directed bench for llr_fetcher: memory model, header/beat capture and timing checks per pattern.
module tb_llr_fetcher;

  typedef struct packed {
    logic [191:0] d;
    logic [4:0]   line;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [9:0] n;
    logic [7:0] k;
    logic [6:0] idx;
  } hdr_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [10:0]  raddr;
  logic [191:0] rdata;
  logic         hdr_valid;
  logic         hdr_ready = 1'b1;
  logic [9:0]   hdr_n;
  logic [7:0]   hdr_k;
  logic [6:0]   hdr_idx;
  logic         llr_valid;
  logic         llr_ready = 1'b1;
  logic [191:0] llr_data;
  logic [4:0]   llr_line;
  logic         llr_last;
  logic         busy;
  logic         done;
  logic         err;

  llr_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .raddr(raddr), .rdata(rdata),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_n(hdr_n), .hdr_k(hdr_k), .hdr_idx(hdr_idx),
    .llr_valid(llr_valid), .llr_ready(llr_ready), .llr_data(llr_data), .llr_line(llr_line),
    .llr_last(llr_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [191:0] mem [0:2047];
  always @(posedge clk) rdata <= mem[raddr];

  int errors = 0;
  int checks = 0;
  beat_t got_b[$], exp_b[$];
  hdr_t  got_h[$], exp_h[$];
  int    got_a[$], exp_a[$];
  int    beat_cyc[$], hdr_cyc[$];
  int    done_cyc, valid_cnt, bubbles;
  bit    both_seen;
  int    pn[3], pk[3];

  function automatic logic [191:0] mkline(input int a);
    logic [191:0] l;
    for (int i = 0; i < 16; i++) l[12*i +: 12] = 12'(a * 37 + i * 251);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Program memory for cnt packets from pn/pk and build the expected streams.
  task automatic setup(input int cnt);
    logic [191:0] h;
    int base, nl;
    got_b.delete(); exp_b.delete(); got_h.delete(); exp_h.delete();
    got_a.delete(); exp_a.delete(); beat_cyc.delete(); hdr_cyc.delete();
    mem[0] = 192'(cnt);
    exp_a.push_back(0);
    if (cnt > 0) exp_a.push_back(1);
    for (int p = 0; p < cnt; p++) begin
      base = 1 + 33 * p;
      h = '0;
      h[9:0]   = 10'(pn[p]);
      h[17:10] = 8'(pk[p]);
      mem[base] = h;
      if (p > 0) exp_a.push_back(base);
      if (pn[p] == 128 || pn[p] == 256 || pn[p] == 512) begin
        nl = pn[p] / 16;
        exp_h.push_back('{n: 10'(pn[p]), k: 8'(pk[p]), idx: 7'(p)});
        for (int j = 0; j < nl; j++) begin
          exp_b.push_back('{d: mkline(base + 1 + j), line: 5'(j), last: (j == nl - 1)});
          exp_a.push_back(base + 1 + j);
        end
      end
    end
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle after the start edge. Stops on done (plus one cycle) or on a beat of abort_line.
  task automatic run(input int budget, input bit rnd, input int abort_line);
    int    last_a;
    logic  p_lv, p_lr, p_hv, p_hr;
    beat_t p_b, b;
    hdr_t  p_h, h;
    bit    fin, hit;
    last_a = -1; p_lv = 0; p_lr = 0; p_hv = 0; p_hr = 0; p_b = '0; p_h = '0;
    done_cyc = -1; valid_cnt = 0; both_seen = 0; fin = 0; hit = 0;
    for (int cyc = 1; cyc <= budget && !fin && !hit; cyc++) begin
      if (rnd) begin
        hdr_ready = 1'($urandom_range(0, 1));
        llr_ready = 1'($urandom_range(0, 1));
      end else begin
        hdr_ready = 1'b1;
        llr_ready = 1'b1;
      end
      if (int'(raddr) != last_a) begin
        got_a.push_back(int'(raddr));
        last_a = int'(raddr);
      end
      b = {llr_data, llr_line, llr_last};
      h = {hdr_n, hdr_k, hdr_idx};
      if (p_lv && !p_lr) begin
        chk("llr_hold_vld", llr_valid, 1);
        chk("llr_hold_dat", b, p_b);
      end
      if (p_hv && !p_hr) begin
        chk("hdr_hold_vld", hdr_valid, 1);
        chk("hdr_hold_dat", h, p_h);
      end
      if (hdr_valid && llr_valid) both_seen = 1;
      if (hdr_valid || llr_valid) valid_cnt++;
      if (hdr_valid && hdr_ready) begin
        got_h.push_back(h);
        hdr_cyc.push_back(cyc);
      end
      if (llr_valid && llr_ready) begin
        got_b.push_back(b);
        beat_cyc.push_back(cyc);
      end
      if (abort_line >= 0 && llr_valid && llr_ready && int'(llr_line) == abort_line) begin
        hit = 1;
      end else begin
        if (done) begin
          done_cyc = cyc;
          fin = 1;
        end
        p_lv = llr_valid; p_lr = llr_ready; p_b = b;
        p_hv = hdr_valid; p_hr = hdr_ready; p_h = h;
        @(posedge clk); #1;
      end
    end
    if (abort_line < 0) begin
      chk("done_seen", (done_cyc >= 0), 1);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
    chk("valids_exclusive", both_seen, 0);
  endtask

  task automatic cmp_all();
    chk("raddr_count", got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      chk($sformatf("raddr%0d", i), got_a[i], exp_a[i]);
    chk("hdr_count", got_h.size(), exp_h.size());
    for (int i = 0; i < got_h.size() && i < exp_h.size(); i++)
      chk($sformatf("hdr%0d", i), got_h[i], exp_h[i]);
    chk("beat_count", got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      chk($sformatf("beat%0d", i), got_b[i], exp_b[i]);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = mkline(a);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_raddr", raddr, 0);
    chk("rst_flags", {hdr_valid, llr_valid, busy, done, err, llr_last}, 0);
    chk("rst_llr", {llr_data, llr_line}, 0);
    chk("rst_hdr", {hdr_n, hdr_k, hdr_idx}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One 128-packet, readies high: exact cycle timing
    pn[0] = 128; pk[0] = 64;
    setup(1); kick(); run(200, 0, -1); cmp_all();
    chk("t1_hdr_cyc", (hdr_cyc.size() > 0) ? hdr_cyc[0] : -1, 5);
    for (int j = 0; j < 8; j++)
      chk($sformatf("t1_beat_cyc%0d", j), (beat_cyc.size() > j) ? beat_cyc[j] : -1, 7 + j);
    chk("t1_done_cyc", done_cyc, 15);

    // 256 then 512 packets
    pn[0] = 256; pk[0] = 100; pn[1] = 512; pk[1] = 200;
    setup(2); kick(); run(500, 0, -1); cmp_all();
    if (beat_cyc.size() == 48 && hdr_cyc.size() == 2) begin
      bubbles = 0;
      for (int j = 0; j < 47; j++)
        if (j != 15 && beat_cyc[j+1] != beat_cyc[j] + 1) bubbles++;
      chk("t2_bubbles", bubbles, 0);
      chk("t2_hdr1_cyc", hdr_cyc[1], beat_cyc[15] + 3);
      chk("t2_pkt1_first", beat_cyc[16], hdr_cyc[1] + 2);
      chk("t2_done_cyc", done_cyc, beat_cyc[47] + 1);
    end else begin
      chk("t2_timing_capture", {beat_cyc.size(), hdr_cyc.size()}, {32'd48, 32'd2});
    end

    // Three packets with random backpressure
    pn[0] = 128; pk[0] = 10; pn[1] = 512; pk[1] = 20; pn[2] = 256; pk[2] = 30;
    setup(3); kick(); run(3000, 1, -1); cmp_all();
    hdr_ready = 1'b1; llr_ready = 1'b1;

    // Empty pattern
    setup(0); kick(); run(50, 0, -1); cmp_all();
    chk("t4_done_cyc", done_cyc, 3);
    chk("t4_no_valid", valid_cnt, 0);

    // Invalid N on packet 0
    pn[0] = 100; pk[0] = 50; pn[1] = 128; pk[1] = 60;
    setup(2); kick(); run(300, 0, -1); cmp_all();
    chk("t5_err_set", err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_err_sticky", err, 1);

    // Reset during beat 5 of a 512-packet, then replay
    pn[0] = 512; pk[0] = 99;
    setup(1); kick();
    chk("t6_err_cleared", err, 0);
    run(200, 0, 5);
    chk("t6_beats_before_rst", got_b.size(), 6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_raddr", raddr, 0);
    chk("t6_rst_flags", {hdr_valid, llr_valid, busy, done, err, llr_last}, 0);
    chk("t6_rst_llr", {llr_data, llr_line}, 0);
    chk("t6_rst_hdr", {hdr_n, hdr_k, hdr_idx}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    setup(1); kick(); run(300, 0, -1); cmp_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/llr_fetcher.md
# llr_fetcher

Upstream front end of the polar decoder. It walks the LLR memory one packet at a time, reading the pattern's packet count, then each packet's N/K header, then that packet's LLR lines. It delivers headers and 16-LLR lines to the SC decoder core over valid/ready handshakes, so the core never addresses LLR memory itself.

## Interface
- `LLR_W`, default 12: signed LLR width.
- `LLRS_PER_LINE`, default 16: LLRs per memory line (line width = 192).
- `PKT_STRIDE`, default 33: memory lines per packet (1 header line + 32 LLR lines).
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a pattern. Sampled only in IDLE.
- `raddr`, out, 11: LLR memory read address (registered).
- `rdata`, in, 192: LLR memory data. Valid in the cycle after the matching `raddr`.
- `hdr_valid`, out, 1: packet header available.
- `hdr_ready`, in, 1: core accepts the header.
- `hdr_n`, out, 10: N (128/256/512).
- `hdr_k`, out, 8: K.
- `hdr_idx`, out, 7: 0-based packet index.
- `llr_valid`, out, 1: LLR line available.
- `llr_ready`, in, 1: core accepts the line.
- `llr_data`, out, 192: LLR i of the line at bits [12i+11:12i], two's complement.
- `llr_line`, out, 5: line index within the packet, 0..N/16-1.
- `llr_last`, out, 1: high with the final line of a packet.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the whole pattern has been delivered.
- `err`, out, 1: sticky. Set on an invalid N; cleared on `start`.

## Operation
- Memory map:
  - addr 0: packet count in `rdata[6:0]`.
  - Packet p header at base_p = 1 + 33p: N = `rdata[9:0]`, K = `rdata[17:10]`.
  - LLR line j of packet p at base_p + 1 + j, for j < N/16.
  - base_p is kept in an accumulator that adds `PKT_STRIDE` per packet. No multiplier.
- State machine:
  - IDLE: on `start`, issue `raddr`=0, clear `err`, go to CNT_WAIT.
  - CNT_WAIT: wait one cycle for memory data.
  - CNT: latch the count. If the count is 0, go to FIN. Otherwise issue `raddr` = base_0 = 1 and go to HDR_WAIT.
  - HDR_WAIT: wait one cycle for memory data.
  - HDR: latch N and K.
    - If N ∉ {128, 256, 512}: set `err`, skip the packet without asserting `hdr_valid`, and advance to the next packet (or FIN).
    - Otherwise assert `hdr_valid` and go to STREAM.
  - STREAM: issue reads for lines 0..N/16-1 into a 2-entry output FIFO. The FIFO head drives `llr_*`.
    - A read may be issued in a cycle only if (FIFO occupancy after this cycle's pop) + (reads in flight) < 2. This guarantees no overflow and no lost data.
    - After the `llr_last` handshake: if packets remain, issue the next header read and go to HDR_WAIT; otherwise go to FIN.
  - FIN: pulse `done`, go to IDLE.
- Header handshake: the header registers are held stable while `hdr_valid` is high and `hdr_ready` is low. LLR reads for the packet begin in the cycle of the `hdr_valid && hdr_ready` handshake.
- LLR handshake: the line transfers when `llr_valid && llr_ready`. `llr_data`, `llr_line` and `llr_last` stay stable while stalled.
- `llr_last` is asserted exactly when `llr_line` = N/16-1.
- `start` while `busy` is ignored.
- `hdr_valid` and `llr_valid` are never high in the same cycle.

## Timing
- Reset values: all outputs are 0, `raddr` = 0, state = IDLE, FIFO empty, `err` = 0.
- Reset mid-operation returns to IDLE on the next edge, discards in-flight data, and drops `done` (no pulse).
- `start` seen at edge t:
  - `raddr` = 0 during t+1, count data arrives in t+2, header address is driven in t+3.
  - With a count of 0, `done` is high in t+3.
- Header address driven in cycle h: `hdr_valid` rises in h+2.
- Header accepted in cycle a with `llr_ready` held high: `llr_valid` rises in a+2, then one line per cycle with no bubbles. A 128-packet takes 8 consecutive beats.
- `done` is high in the cycle after the last `llr_last` handshake of the last packet.
- Stall: a beat held for any number of cycles resumes at full rate. No line is duplicated or skipped.

## Test plan
- Count = 1, N=128, K=64, LLR lines hold incrementing values, `hdr_ready`/`llr_ready` tied high:
  - `raddr` sequence is 0, 1, 2..9.
  - 8 consecutive beats with `llr_line` 0..7 and `llr_last` on beat 7.
  - Header fields: `hdr_n`=128, `hdr_k`=64, `hdr_idx`=0.
  - One `done` pulse.
- Count = 2, packet 0 N=256, packet 1 N=512:
  - Packet 1 header read at `raddr`=34.
  - 32 beats read from addresses 35..66.
  - `hdr_idx`=1 for the second header.
  - 48 beats total.
- Count = 3, random `hdr_ready`/`llr_ready` (50% duty): the beat stream is bit-exact with memory contents, in order, with no duplicates and outputs stable during stalls.
- Count = 0: `done` is high exactly 3 cycles after `start` and neither valid is ever asserted.
- Count = 2, packet 0 N=100: `err`=1, no header or LLR output for packet 0, packet 1 is delivered normally, `err` stays 1 until the next `start`.
- Assert `rst_n`=0 during beat 5 of an N=512 packet: all outputs are 0 on the next edge, and a new `start` replays the pattern from `raddr`=0 correctly.
